audio_source_arbiter: RTL and testbench

Shares the single 16-bit `sound` path into `i2s_audio_out` between up to `n_src` sample producers (tone generators, mic loopback, sample player). It generates the audio sample tick from the system clock and grants the path to one requester at a time, round-robin, on sample boundaries. The granted source's samples are forwarded at exactly one per tick. Starved or silent owners are revoked so that no single source can lock the path.

---
 rtl/audio_arb_pkg.sv | 25 ++
 rtl/sample_tick_gen.sv | 42 ++++
 rtl/audio_source_arbiter.sv | 169 ++++++++++++++++
 tb/tb_audio_source_arbiter.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/audio_arb_pkg.sv
// rtl/audio_arb_pkg.sv - shared types and helpers for the audio source arbiter
// Contents:
//   arb_state_t  : arbiter state (IDLE / OWNED)
//   tick_period  : system clocks per audio sample
//   cnt_width    : counter width able to hold 0..p-1
//   DEF_CNT_W    : tick counter width at the default 50 MHz / 48 kHz
package audio_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    function automatic int tick_period(input int clk_mhz, input int sample_rate_hz);
        return (clk_mhz * 1000000) / sample_rate_hz;
    endfunction

    // A period of 1 would give $clog2 == 0; keep at least one bit.
    function automatic int cnt_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

    localparam int DEF_CNT_W = $clog2(tick_period(50, 48000));

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running audio sample tick from the system clock
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (counter cleared to 0)
//   tick  : one-cycle pulse while the count equals P-1, once every P cycles
module sample_tick_gen
    import audio_arb_pkg::*;
#(
    parameter int clk_mhz        = 50,
    parameter int sample_rate_hz = 48000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int P     = tick_period(clk_mhz, sample_rate_hz);
    localparam int CNT_W = cnt_width(P);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(P - 1));
    assign tick = wrap;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/audio_source_arbiter.sv
// rtl/audio_source_arbiter.sv - round-robin owner of the shared sound path, one sample per tick
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   req         : per-source request level
//   valid       : per-source sample-ready flag
//   sample      : per-source samples, slice i at [i*w_sample +: w_sample]
//   ready       : one-cycle pulse, the owner's sample was consumed
//   grant       : one-hot current owner, or zero
//   sound       : registered sample towards the I2S serializer
//   sample_tick : one-cycle pulse every P cycles
//   underrun    : one-cycle pulse, the owner had no sample at a tick
module audio_source_arbiter
    import audio_arb_pkg::*;
#(
    parameter int clk_mhz        = 50,
    parameter int sample_rate_hz = 48000,
    parameter int n_src          = 4,
    parameter int w_sample       = 16,
    parameter int max_underrun   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [n_src-1:0]          req,
    input  logic [n_src-1:0]          valid,
    input  logic [n_src*w_sample-1:0] sample,
    output logic [n_src-1:0]          ready,
    output logic [n_src-1:0]          grant,
    output logic [w_sample-1:0]       sound,
    output logic                      sample_tick,
    output logic                      underrun
);

    localparam int IDX_W = $clog2(n_src);
    localparam int UR_W  = $clog2(max_underrun + 1);

    arb_state_t           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [UR_W-1:0]      urun_q, urun_d;
    logic [w_sample-1:0]  sound_q, sound_d;
    logic [n_src-1:0]     grant_q, grant_d;
    logic [n_src-1:0]     ready_q, ready_d;
    logic                 underrun_q, underrun_d;

    logic                 tick;
    logic                 svc;
    logic                 rearb;
    logic                 hit_found;
    logic [IDX_W-1:0]     hit_idx;
    logic [w_sample-1:0]  owner_sample;

    sample_tick_gen #(
        .clk_mhz        (clk_mhz),
        .sample_rate_hz (sample_rate_hz)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // First requester at or after start, wrapping; MSB of the result is "found".
    function automatic logic [IDX_W:0] rr_search(input logic [n_src-1:0] r,
                                                 input logic [IDX_W-1:0] start);
        logic             found;
        logic [IDX_W-1:0] hit;
        int               idx;
        found = 1'b0;
        hit   = '0;
        for (int i = 0; i < n_src; i++) begin
            idx = int'(start) + i;
            if (idx >= n_src) begin
                idx = idx - n_src;
            end
            if (!found && r[idx]) begin
                found = 1'b1;
                hit   = IDX_W'(idx);
            end
        end
        return {found, hit};
    endfunction

    // Decode: a tick either services a live owner or re-arbitrates. Release of
    // a dead owner and the new grant happen in the same tick.
    always_comb begin
        svc   = tick && (state_q == OWNED) && req[owner_q]
                && (urun_q < UR_W'(max_underrun));
        rearb = tick && !svc;
        {hit_found, hit_idx} = rr_search(req, ptr_q);
        owner_sample = sample[int'(owner_q)*w_sample +: w_sample];
    end

    // Next state
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        urun_d  = urun_q;
        if (svc) begin
            if (valid[owner_q]) begin
                urun_d = '0;
            end else begin
                urun_d = urun_q + UR_W'(1);
            end
        end
        if (rearb) begin
            if (hit_found) begin
                state_d = OWNED;
                owner_d = hit_idx;
                ptr_d   = (hit_idx == IDX_W'(n_src - 1)) ? '0 : hit_idx + IDX_W'(1);
                urun_d  = '0;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Outputs (registered next cycle); a new owner is only granted in its
    // first tick, so sound goes to zero for exactly that sample.
    always_comb begin
        sound_d    = sound_q;
        grant_d    = grant_q;
        ready_d    = '0;
        underrun_d = 1'b0;
        if (svc) begin
            if (valid[owner_q]) begin
                sound_d          = owner_sample;
                ready_d[owner_q] = 1'b1;
            end else begin
                underrun_d = 1'b1;
            end
        end
        if (rearb) begin
            sound_d = '0;
            grant_d = '0;
            if (hit_found) begin
                grant_d[hit_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            urun_q     <= '0;
            sound_q    <= '0;
            grant_q    <= '0;
            ready_q    <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            urun_q     <= urun_d;
            sound_q    <= sound_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
        end
    end

    assign ready       = ready_q;
    assign grant       = grant_q;
    assign sound       = sound_q;
    assign underrun    = underrun_q;
    assign sample_tick = tick;

endmodule

// File: tb/tb_audio_source_arbiter.sv
// tb/tb_audio_source_arbiter.sv - directed self-checking bench for audio_source_arbiter
module tb_audio_source_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [63:0] sample;
    logic [3:0]  ready;
    logic [3:0]  grant;
    logic [15:0] sound;
    logic        sample_tick;
    logic        underrun;

    int n_tests;
    int n_fail;

    audio_source_arbiter #(
        .clk_mhz        (1),
        .sample_rate_hz (100000),
        .n_src          (4),
        .w_sample       (16),
        .max_underrun   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .valid       (valid),
        .sample      (sample),
        .ready       (ready),
        .grant       (grant),
        .sound       (sound),
        .sample_tick (sample_tick),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge inside a tick cycle (bounded).
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (!sample_tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tick_seen", 32'(sample_tick), 32'h1);
    endtask

    initial begin
        int order [4];
        int o;
        logic [15:0] exp_s;

        n_tests = 0;
        n_fail  = 0;
        order   = '{0, 1, 3, 0};
        rst_n   = 1'b0;
        req     = '0;
        valid   = '0;
        sample  = '0;

        // Reset and tick
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_sound", 32'(sound), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_urun",  32'(underrun), 32'h0);
        check("rst_tick",  32'(sample_tick), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("tick_phase", 32'(sample_tick), (i % 10 == 8) ? 32'h1 : 32'h0);
        end
        check("idle_grant", 32'(grant), 32'h0);

        // Single source
        req    = 4'b0100;
        valid  = 4'b0100;
        sample[2*16 +: 16] = 16'h1234;
        wait_tick();
        @(negedge clk);
        check("ss_grant", 32'(grant), 32'h4);
        check("ss_sound0", 32'(sound), 32'h0);
        check("ss_ready0", 32'(ready), 32'h0);
        repeat (4) @(negedge clk);
        check("ss_between", 32'(sound), 32'h0);
        wait_tick();
        @(negedge clk);
        check("ss_sound", 32'(sound), 32'h1234);
        check("ss_ready", 32'(ready), 32'h4);

        // Async reset mid-grant
        #2 rst_n = 1'b0;
        #1;
        check("ar_grant", 32'(grant), 32'h0);
        check("ar_sound", 32'(sound), 32'h0);
        check("ar_ready", 32'(ready), 32'h0);
        req    = 4'b1011;
        valid  = 4'b1111;
        sample = {16'h3333, 16'h2222, 16'h1111, 16'h0AAA};
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin: restart from index 0, each owner drops after 3 samples
        for (int j = 0; j < 4; j++) begin
            o     = order[j];
            exp_s = sample[o*16 +: 16];
            wait_tick();
            @(negedge clk);
            check("rr_grant", 32'(grant), 32'(1 << o));
            check("rr_zero", 32'(sound), 32'h0);
            check("rr_noready", 32'(ready), 32'h0);
            for (int k = 0; k < 3; k++) begin
                wait_tick();
                @(negedge clk);
                check("rr_sound", 32'(sound), 32'(exp_s));
                check("rr_ready", 32'(ready), 32'(1 << o));
            end
            req = 4'b1011 & ~4'(1 << o);
        end
        req   = '0;
        valid = '0;
        wait_tick();
        @(negedge clk);
        check("rr_idle", 32'(grant), 32'h0);

        // Underrun revoke and non-owner isolation
        req = 4'b0110;
        wait_tick();
        @(negedge clk);
        check("ur_grant", 32'(grant), 32'h2);
        valid = 4'b0010;
        sample[1*16 +: 16] = 16'hABCD;
        wait_tick();
        @(negedge clk);
        check("ur_first", 32'(sound), 32'hABCD);
        check("ur_fready", 32'(ready), 32'h2);
        valid = 4'b0100;
        sample[2*16 +: 16] = 16'h7FFF;
        for (int t = 1; t <= 8; t++) begin
            wait_tick();
            @(negedge clk);
            check("ur_pulse", 32'(underrun), 32'h1);
            check("ur_hold", 32'(sound), 32'hABCD);
            check("iso_ready", 32'(ready), 32'h0);
            check("ur_keep", 32'(grant), 32'h2);
            if (t == 1) begin
                @(negedge clk);
                check("ur_width", 32'(underrun), 32'h0);
            end
        end
        wait_tick();
        @(negedge clk);
        check("ur_revoke", 32'(grant), 32'h4);
        check("ur_zero", 32'(sound), 32'h0);
        check("ur_nopulse", 32'(underrun), 32'h0);
        wait_tick();
        @(negedge clk);
        check("new_sound", 32'(sound), 32'h7FFF);
        check("new_ready", 32'(ready), 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
